// File: rtl/bsearch_ctrl.sv
// Binary-search controller: drives probe values into an external magnitude
// comparator and narrows an inclusive [lo, hi] window from its gt/eq/lt flags.
module bsearch_ctrl #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] lo,
   input  logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] probe,
   input  logic             cmp_gt,
   input  logic             cmp_eq,
   input  logic             cmp_lt,
   output logic             busy,
   output logic             done,
   output logic             found,
   output logic             error,
   output logic [WIDTH-1:0] result,
   output logic [CNT_W-1:0] steps
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_CMP  = 2'd2,
      S_FIN  = 2'd3
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] lo_q;
   logic [WIDTH-1:0] hi_q;
   logic [WIDTH-1:0] probe_q;
   logic [WIDTH-1:0] result_q;
   logic [CNT_W-1:0] steps_q;
   logic             busy_q;
   logic             done_q;
   logic             found_q;
   logic             error_q;

   // Midpoint is formed one bit wider so hi - lo never wraps; the result
   // always fits back into WIDTH bits because it lies inside [lo, hi].
   logic [WIDTH-1:0] mid_d;
   logic [CNT_W-1:0] steps_d;

   always_comb begin
      mid_d   = WIDTH'({1'b0, lo_q} + (({1'b0, hi_q} - {1'b0, lo_q}) >> 1));
      steps_d = (steps_q == {CNT_W{1'b1}}) ? steps_q : steps_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         lo_q     <= '0;
         hi_q     <= '0;
         probe_q  <= '0;
         result_q <= '0;
         steps_q  <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         found_q  <= 1'b0;
         error_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  lo_q     <= lo;
                  hi_q     <= hi;
                  steps_q  <= '0;
                  found_q  <= 1'b0;
                  error_q  <= 1'b0;
                  result_q <= '0;
                  busy_q   <= 1'b1;
                  state_q  <= S_CALC;
               end
            end
            S_CALC: begin
               if (lo_q > hi_q) begin
                  found_q <= 1'b0;
                  state_q <= S_FIN;
               end else begin
                  probe_q <= mid_d;
                  steps_q <= steps_d;
                  state_q <= S_CMP;
               end
            end
            S_CMP: begin
               // Edge bounds are checked before stepping so lo-1 / hi+1 never wrap.
               case ({cmp_gt, cmp_eq, cmp_lt})
                  3'b010: begin
                     result_q <= probe_q;
                     found_q  <= 1'b1;
                     state_q  <= S_FIN;
                  end
                  3'b100: begin
                     if (probe_q == lo_q) begin
                        state_q <= S_FIN;
                     end else begin
                        hi_q    <= probe_q - WIDTH'(1);
                        state_q <= S_CALC;
                     end
                  end
                  3'b001: begin
                     if (probe_q == hi_q) begin
                        state_q <= S_FIN;
                     end else begin
                        lo_q    <= probe_q + WIDTH'(1);
                        state_q <= S_CALC;
                     end
                  end
                  default: begin
                     error_q <= 1'b1;
                     found_q <= 1'b0;
                     state_q <= S_FIN;
                  end
               endcase
            end
            S_FIN: begin
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign probe  = probe_q;
   assign busy   = busy_q;
   assign done   = done_q;
   assign found  = found_q;
   assign error  = error_q;
   assign result = result_q;
   assign steps  = steps_q;

endmodule
